encoder_scheduler: RTL

- Time-multiplexes one shared quadrature-decode datapath across CHANNELS rotary encoders, e.g. the three R/G/B knobs.
- Keeps per-channel state (previous a/b, count value) in registers and services one channel per clock in round-robin order.
- Provides a host load port so the top level can preset or clear any channel's count.
- Feeds the PWM/colour logic with a flattened value bus plus an update strobe.

---
 rtl/encoder_pkg.sv | 29 ++
 rtl/quad_step.sv | 63 ++++++
 rtl/encoder_scheduler.sv | 119 +++++++++++
 3 files changed

// File: rtl/encoder_pkg.sv
// -----------------------------------------------------------------------------
// encoder_pkg
// Shared definitions for the time-multiplexed quadrature encoder scheduler.
//   - QD_* : 4-bit decode patterns, ordered {a_new, a_old, b_new, b_old}
//   - dir_e: step direction produced by a decoded pattern
//   - qd_direction(): maps a pattern to a direction
// -----------------------------------------------------------------------------
package encoder_pkg;

  localparam logic [3:0] QD_INC_A = 4'b1000;  // A rises while B low
  localparam logic [3:0] QD_INC_B = 4'b0111;  // A falls while B high
  localparam logic [3:0] QD_DEC_A = 4'b0010;  // B rises while A low
  localparam logic [3:0] QD_DEC_B = 4'b1101;  // B falls while A high

  typedef enum logic [1:0] {
    DIR_HOLD = 2'd0,
    DIR_INC  = 2'd1,
    DIR_DEC  = 2'd2
  } dir_e;

  function automatic dir_e qd_direction(input logic [3:0] pattern);
    case (pattern)
      QD_INC_A, QD_INC_B: return DIR_INC;
      QD_DEC_A, QD_DEC_B: return DIR_DEC;
      default:            return DIR_HOLD;
    endcase
  endfunction

endpackage

// File: rtl/quad_step.sv
// -----------------------------------------------------------------------------
// quad_step
// Combinational quadrature step shared by all encoder channels.
// Decodes one 4-bit pattern and applies +/- increment to the current count.
// Optional macro: ENCODER_SATURATE_EN -- clamp at 0 / 2^WIDTH-1 instead of
// wrapping modulo 2^WIDTH.
// Ports:
//   pattern    in  4      {a_new, a_old, b_new, b_old}
//   value      in  WIDTH  current channel count
//   increment  in  WIDTH  step size
//   next_value out WIDTH  count after this step
//   changed    out 1      next_value differs from value
// -----------------------------------------------------------------------------
module quad_step
  import encoder_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic [3:0]       pattern,
  input  logic [WIDTH-1:0] value,
  input  logic [WIDTH-1:0] increment,
  output logic [WIDTH-1:0] next_value,
  output logic             changed
);

  dir_e dir;

`ifdef ENCODER_SATURATE_EN
  // Extra MSB carries the overflow/borrow used for clamping.
  logic [WIDTH:0] sum;
  logic [WIDTH:0] diff;
`else
  logic [WIDTH-1:0] sum;
  logic [WIDTH-1:0] diff;
`endif

  always_comb begin
    // NOTE: every output gets a default before the case, so no path leaves
    // a variable unassigned and no latch is inferred.
    next_value = value;
    dir        = qd_direction(pattern);
`ifdef ENCODER_SATURATE_EN
    sum  = {1'b0, value} + {1'b0, increment};
    diff = {1'b0, value} - {1'b0, increment};
    case (dir)
      DIR_INC: next_value = sum[WIDTH]  ? '1 : sum[WIDTH-1:0];
      DIR_DEC: next_value = diff[WIDTH] ? '0 : diff[WIDTH-1:0];
      default: next_value = value;
    endcase
`else
    sum  = value + increment;
    diff = value - increment;
    case (dir)
      DIR_INC: next_value = sum;
      DIR_DEC: next_value = diff;
      default: next_value = value;
    endcase
`endif
    // A clamped step leaves the count unchanged and must not raise an update.
    changed = (next_value != value);
  end

endmodule

// File: rtl/encoder_scheduler.sv
// -----------------------------------------------------------------------------
// encoder_scheduler
// Time-multiplexes one quadrature decoder (quad_step) across CHANNELS rotary
// encoders, servicing one channel per clock in round-robin order.
// Optional macro: ENCODER_SATURATE_EN -- counts clamp instead of wrapping.
// Ports:
//   clk         in  1                 system clock
//   reset       in  1                 asynchronous active-low reset
//   enable      in  1                 run scheduler; low freezes ptr and state
//   a, b        in  CHANNELS          raw encoder phases (asynchronous)
//   load_valid  in  1                 host write strobe
//   load_ch     in  CH_BITS           channel to write (>= CHANNELS ignored)
//   load_data   in  WIDTH             value to write
//   values      out CHANNELS*WIDTH    channel k at [k*WIDTH +: WIDTH]
//   upd_valid   out 1                 pulse: a count changed by decode
//   upd_ch      out CH_BITS           channel that changed
// -----------------------------------------------------------------------------
module encoder_scheduler
  import encoder_pkg::*;
#(
  parameter  int               CHANNELS  = 3,
  parameter  int               WIDTH     = 8,
  parameter  logic [WIDTH-1:0] INCREMENT = WIDTH'(1),
  localparam int               CH_BITS   = $clog2(CHANNELS)
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      enable,
  input  logic [CHANNELS-1:0]       a,
  input  logic [CHANNELS-1:0]       b,
  input  logic                      load_valid,
  input  logic [CH_BITS-1:0]        load_ch,
  input  logic [WIDTH-1:0]          load_data,
  output logic [CHANNELS*WIDTH-1:0] values,
  output logic                      upd_valid,
  output logic [CH_BITS-1:0]        upd_ch
);

  localparam logic [CH_BITS-1:0] LAST_CH = CH_BITS'(CHANNELS - 1);

  // Two-flop synchronizers for the asynchronous encoder phases.
  logic [CHANNELS-1:0] a_meta, a_s;
  logic [CHANNELS-1:0] b_meta, b_s;

  // Per-channel state.
  logic [CHANNELS-1:0] old_a, old_b;
  logic [WIDTH-1:0]    count_q [CHANNELS];

  logic [CH_BITS-1:0]  ptr;

  logic [3:0]          pattern;
  logic [WIDTH-1:0]    step_value;
  logic                step_changed;
  logic                load_ok;
  logic                load_hit;

  assign pattern  = {a_s[ptr], old_a[ptr], b_s[ptr], old_b[ptr]};
  assign load_ok  = load_valid && (int'(load_ch) < CHANNELS);
  // A host write to the channel being serviced overrides the decode result.
  assign load_hit = load_ok && (load_ch == ptr);

  quad_step #(
    .WIDTH (WIDTH)
  ) u_quad_step (
    .pattern    (pattern),
    .value      (count_q[ptr]),
    .increment  (INCREMENT),
    .next_value (step_value),
    .changed    (step_changed)
  );

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      a_meta    <= '0;
      a_s       <= '0;
      b_meta    <= '0;
      b_s       <= '0;
      old_a     <= '0;
      old_b     <= '0;
      ptr       <= '0;
      upd_valid <= 1'b0;
      upd_ch    <= '0;
      // NOTE: the count "memory" is a small flop array, not a RAM macro, so
      // clearing it in the async reset branch is both legal and required.
      for (int k = 0; k < CHANNELS; k++) begin
        count_q[k] <= '0;
      end
    end else begin
      // Synchronizers run every cycle, independent of enable.
      a_meta    <= a;
      a_s       <= a_meta;
      b_meta    <= b;
      b_s       <= b_meta;
      upd_valid <= 1'b0;

      if (enable) begin
        old_a[ptr] <= a_s[ptr];
        old_b[ptr] <= b_s[ptr];
        ptr        <= (ptr == LAST_CH) ? '0 : ptr + 1'b1;
        if (step_changed && !load_hit) begin
          count_q[ptr] <= step_value;
          upd_valid    <= 1'b1;
          upd_ch       <= ptr;
        end
      end

      if (load_ok) begin
        count_q[load_ch] <= load_data;
      end
    end
  end

  for (genvar k = 0; k < CHANNELS; k++) begin : g_flatten
    assign values[k*WIDTH +: WIDTH] = count_q[k];
  end

endmodule
